// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, one quotient bit per clock, start/busy/done handshake; optional DIV_FAST_PATH_EN macro finishes early when dividend < divisor
module seq_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);
  typedef enum logic [1:0] {IDLE, RUN, FIN, ZERO} state_t;
  localparam int CW = $clog2(DIVIDEND_W + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [DIVISOR_W-1:0] dvs;
  logic [DIVISOR_W:0] pr, pr_sh;
  logic [DIVIDEND_W-1:0] q;
  logic dz, ge, fast, accept, zero_in;
  assign pr_sh = (DIVISOR_W + 1)'({pr, q[DIVIDEND_W-1]});
  assign ge = pr_sh >= {1'b0, dvs};
  assign accept = state == IDLE && start;
  assign zero_in = divisor == '0;
`ifdef DIV_FAST_PATH_EN
  assign fast = !zero_in && dividend < {{(DIVIDEND_W - DIVISOR_W){1'b0}}, divisor};
`else
  assign fast = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = IDLE;
    busy = 1'b0;
    done = 1'b0;
    state_n = state == IDLE ? (start ? (zero_in ? ZERO : fast ? FIN : RUN) : IDLE)
            : state == RUN ? (cnt == CW'(DIVIDEND_W - 1) ? FIN : RUN) : IDLE;
    busy = state == RUN;
    done = state == FIN || state == ZERO;
  end
  // q doubles as the dividend shift register: dividend bits leave at the MSB while quotient bits enter at the LSB
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      dvs <= '0;
      pr <= '0;
      q <= '0;
      dz <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      dvs <= divisor;
      dz <= zero_in;
      q <= zero_in ? '1 : fast ? '0 : dividend;
      pr <= fast ? {1'b0, dividend[DIVISOR_W-1:0]} : '0;
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      q <= {q[DIVIDEND_W-2:0], ge};
      pr <= ge ? pr_sh - {1'b0, dvs} : pr_sh;
    end
  assign quotient = q;
  assign remainder = DIVISOR_W'(pr);
  assign div_by_zero = dz;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider against an arithmetic reference
module tb_seq_divider;
  logic clk = 0, rst = 1, start = 0;
  logic [7:0] dividend = 0, quotient;
  logic [3:0] divisor = 0, remainder;
  logic busy, done, div_by_zero;
  int pass = 0, total = 0;
  seq_divider dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask
  task automatic go(input logic [7:0] a, input logic [3:0] b);
    int lat, nb, el;
    logic [7:0] eq;
    logic [3:0] er;
    eq = b == 0 ? 8'hff : 8'(int'(a) / int'(b));
    er = b == 0 ? 4'd0 : 4'(int'(a) % int'(b));
    el = b == 0 ? 0 : 8;
`ifdef DIV_FAST_PATH_EN
    if (b != 0 && a < 8'(b)) el = 0;
`endif
    dividend = a;
    divisor = b;
    start = 1;
    @(negedge clk);
    start = 0;
    lat = 0;
    nb = 0;
    while (!done && lat < 30) begin
      nb += int'(busy);
      @(negedge clk);
      lat++;
    end
    check($sformatf("latency %0d/%0d", a, b), lat, el);
    check($sformatf("busy_cycles %0d/%0d", a, b), nb, el);
    check($sformatf("quotient %0d/%0d", a, b), quotient, eq);
    check($sformatf("remainder %0d/%0d", a, b), remainder, er);
    check($sformatf("div_by_zero %0d/%0d", a, b), div_by_zero, b == 0);
    if (b != 0) check($sformatf("invariant %0d/%0d", a, b), int'(quotient) * int'(b) + int'(remainder), a);
    @(negedge clk);
    check($sformatf("done_pulse %0d/%0d", a, b), done, 0);
    check($sformatf("hold_q %0d/%0d", a, b), quotient, eq);
  endtask
  initial begin
    int dn, k;
    logic [7:0] sq;
    logic [3:0] sr;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_q", quotient, 0);
    check("reset_r", remainder, 0);
    check("reset_dz", div_by_zero, 0);
    rst = 0;
    go(120, 12);
    go(220, 15);
    go(255, 1);
    go(200, 0);
    go(156, 12);
    go(7, 9);
    go(0, 5);
    go(15, 15);
    // second start while busy must be ignored
    dividend = 120;
    divisor = 12;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    dividend = 99;
    divisor = 5;
    start = 1;
    @(negedge clk);
    start = 0;
    dn = 0;
    sq = 0;
    sr = 0;
    for (int i = 0; i < 14; i++) begin
      if (done) begin
        dn++;
        sq = quotient;
        sr = remainder;
      end
      @(negedge clk);
    end
    check("ignored_done_count", dn, 1);
    check("ignored_q", sq, 10);
    check("ignored_r", sr, 0);
    // reset in the middle of a division
    dividend = 156;
    divisor = 12;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_q", quotient, 0);
    check("abort_r", remainder, 0);
    check("abort_dz", div_by_zero, 0);
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      dn += int'(done);
      @(negedge clk);
    end
    check("abort_no_done", dn, 0);
    go(132, 11);
    // start held high: next op accepted in the IDLE cycle after done
    dividend = 50;
    divisor = 7;
    start = 1;
    @(negedge clk);
    k = 0;
    while (!done && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("held_first_q", quotient, 7);
    check("held_first_r", remainder, 1);
    @(negedge clk);
    check("held_idle_busy", busy, 0);
    check("held_idle_done", done, 0);
    @(negedge clk);
    check("held_reaccept_busy", busy, 1);
    start = 0;
    k = 0;
    while (!done && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("held_second_q", quotient, 7);
    check("held_second_r", remainder, 1);
    @(negedge clk);
    for (int i = 0; i < 25; i++) go(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
